// File: rtl/dma_pcie_dsc_cpld_arb.sv
`default_nettype none
// ============================================================================
// Module   : dma_pcie_dsc_cpld_arb
// Brief    : Round-robin write arbiter and fully pipelined read path for the
//            descriptor-completion RAM, with byte-parity generation/check and
//            saturating error counters.
// Revision : 1.0 - initial release
// ============================================================================
module dma_pcie_dsc_cpld_arb #(
  parameter int RD_LAT = 2  // RAM read latency (ram_ren -> ram_rdat), 1..4
) (
  input  logic         clk,
  input  logic         rst,
  // requester 0 write channel
  input  logic         wr0_vld,
  output logic         wr0_rdy,
  input  logic [9:0]   wr0_adr,
  input  logic [7:0]   wr0_be,
  input  logic [511:0] wr0_dat,
  // requester 1 write channel
  input  logic         wr1_vld,
  output logic         wr1_rdy,
  input  logic [9:0]   wr1_adr,
  input  logic [7:0]   wr1_be,
  input  logic [511:0] wr1_dat,
  // read request
  input  logic         rd_vld,
  output logic         rd_rdy,
  input  logic [9:0]   rd_adr,
  // read return
  output logic         rd_out_vld,
  output logic [511:0] rd_out_dat,
  output logic         rd_out_sbe,
  output logic         rd_out_dbe,
  output logic         rd_out_perr,
  // RAM master
  output logic [9:0]   ram_wadr,
  output logic [7:0]   ram_wen,
  output logic [63:0]  ram_wpar,
  output logic [511:0] ram_wdat,
  output logic         ram_ren,
  output logic [9:0]   ram_radr,
  input  logic [63:0]  ram_rpar,
  input  logic [511:0] ram_rdat,
  input  logic         ram_rsbe,
  input  logic         ram_rdbe,
  // error counters
  input  logic         err_clr,
  output logic [15:0]  sbe_cnt,
  output logic [15:0]  dbe_cnt,
  output logic [15:0]  perr_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // registered state
  logic              last_q,     last_d;     // 1: wr1 held the most recent grant
  logic [9:0]        ram_wadr_q, ram_wadr_d;
  logic [7:0]        ram_wen_q,  ram_wen_d;
  logic [63:0]       ram_wpar_q, ram_wpar_d;
  logic [511:0]      ram_wdat_q, ram_wdat_d;
  logic              ram_ren_q,  ram_ren_d;
  logic [9:0]        ram_radr_q, ram_radr_d;
  logic [RD_LAT-1:0] vld_sr_q,   vld_sr_d;   // tracks reads in flight inside the RAM
  logic              out_vld_q,  out_vld_d;
  logic [511:0]      out_dat_q,  out_dat_d;
  logic              out_sbe_q,  out_sbe_d;
  logic              out_dbe_q,  out_dbe_d;
  logic              out_perr_q, out_perr_d;
  logic [15:0]       sbe_cnt_q,  sbe_cnt_d;
  logic [15:0]       dbe_cnt_q,  dbe_cnt_d;
  logic [15:0]       perr_cnt_q, perr_cnt_d;

  // combinational
  logic         gnt0;
  logic         gnt1;
  logic         wr_any;
  logic [9:0]   wr_adr;
  logic [7:0]   wr_be;
  logic [511:0] wr_dat;
  logic [63:0]  wr_par;
  logic         rd_ok;
  logic         rd_acc;
  logic [63:0]  rd_par_calc;
  logic         rd_perr;
  logic         rd_tail;

  // Round-robin grant, winning-write mux and read-after-write hazard stall
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      // wr0 wins if alone, or under contention when wr1 was granted last
      if (wr0_vld && (!wr1_vld || last_q)) begin
        gnt0 = 1'b1;
      end else if (wr1_vld) begin
        gnt1 = 1'b1;
      end
    end
    wr_any = gnt0 | gnt1;
    wr_adr = gnt1 ? wr1_adr : wr0_adr;
    wr_be  = gnt1 ? wr1_be  : wr0_be;
    wr_dat = gnt1 ? wr1_dat : wr0_dat;
    // a read to the address being written this cycle waits one cycle so it
    // observes the new data
    rd_ok  = !rst && !(rd_vld && wr_any && (rd_adr == wr_adr));
    rd_acc = rd_vld && rd_ok;
  end

  // Even byte parity for the outgoing write and check of the returned read
  always_comb begin
    wr_par      = '0;
    rd_par_calc = '0;
    for (int i = 0; i < 64; i++) begin
      wr_par[i]      = ^wr_dat[8*i +: 8];
      rd_par_calc[i] = ^ram_rdat[8*i +: 8];
    end
    rd_perr = |(rd_par_calc ^ ram_rpar);
    rd_tail = vld_sr_q[RD_LAT-1];
  end

  // Next-state computation for the write, read and counter registers
  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end

    ram_wen_d  = wr_any ? wr_be  : 8'h00;
    ram_wadr_d = wr_any ? wr_adr : ram_wadr_q;
    ram_wdat_d = wr_any ? wr_dat : ram_wdat_q;
    ram_wpar_d = wr_any ? wr_par : ram_wpar_q;

    ram_ren_d  = rd_acc;
    ram_radr_d = rd_acc ? rd_adr : ram_radr_q;

    vld_sr_d    = '0;
    vld_sr_d[0] = ram_ren_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end

    out_vld_d  = rd_tail;
    out_dat_d  = rd_tail ? ram_rdat : out_dat_q;
    out_sbe_d  = rd_tail & ram_rsbe;
    out_dbe_d  = rd_tail & ram_rdbe;
    out_perr_d = rd_tail & rd_perr;

    // clear takes priority over a coincident increment
    sbe_cnt_d = sbe_cnt_q;
    if (err_clr) begin
      sbe_cnt_d = '0;
    end else if (out_sbe_q && (sbe_cnt_q != CNT_MAX)) begin
      sbe_cnt_d = sbe_cnt_q + 16'd1;
    end

    dbe_cnt_d = dbe_cnt_q;
    if (err_clr) begin
      dbe_cnt_d = '0;
    end else if (out_dbe_q && (dbe_cnt_q != CNT_MAX)) begin
      dbe_cnt_d = dbe_cnt_q + 16'd1;
    end

    perr_cnt_d = perr_cnt_q;
    if (err_clr) begin
      perr_cnt_d = '0;
    end else if (out_perr_q && (perr_cnt_q != CNT_MAX)) begin
      perr_cnt_d = perr_cnt_q + 16'd1;
    end
  end

  // State registers; reset flushes the read pipeline and parks the pointer on wr1
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      ram_wadr_q <= '0;
      ram_wen_q  <= '0;
      ram_wpar_q <= '0;
      ram_wdat_q <= '0;
      ram_ren_q  <= 1'b0;
      ram_radr_q <= '0;
      vld_sr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_sbe_q  <= 1'b0;
      out_dbe_q  <= 1'b0;
      out_perr_q <= 1'b0;
      sbe_cnt_q  <= '0;
      dbe_cnt_q  <= '0;
      perr_cnt_q <= '0;
    end else begin
      last_q     <= last_d;
      ram_wadr_q <= ram_wadr_d;
      ram_wen_q  <= ram_wen_d;
      ram_wpar_q <= ram_wpar_d;
      ram_wdat_q <= ram_wdat_d;
      ram_ren_q  <= ram_ren_d;
      ram_radr_q <= ram_radr_d;
      vld_sr_q   <= vld_sr_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_sbe_q  <= out_sbe_d;
      out_dbe_q  <= out_dbe_d;
      out_perr_q <= out_perr_d;
      sbe_cnt_q  <= sbe_cnt_d;
      dbe_cnt_q  <= dbe_cnt_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  assign wr0_rdy     = gnt0;
  assign wr1_rdy     = gnt1;
  assign rd_rdy      = rd_ok;
  assign ram_wadr    = ram_wadr_q;
  assign ram_wen     = ram_wen_q;
  assign ram_wpar    = ram_wpar_q;
  assign ram_wdat    = ram_wdat_q;
  assign ram_ren     = ram_ren_q;
  assign ram_radr    = ram_radr_q;
  assign rd_out_vld  = out_vld_q;
  assign rd_out_dat  = out_dat_q;
  assign rd_out_sbe  = out_sbe_q;
  assign rd_out_dbe  = out_dbe_q;
  assign rd_out_perr = out_perr_q;
  assign sbe_cnt     = sbe_cnt_q;
  assign dbe_cnt     = dbe_cnt_q;
  assign perr_cnt    = perr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_pcie_dsc_cpld_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_pcie_dsc_cpld_arb
// Brief    : Self-checking bench for dma_pcie_dsc_cpld_arb: RAM model,
//            cycle-scheduled reference model, directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_pcie_dsc_cpld_arb;

  localparam int RD_LAT = 2;
  localparam int RET    = RD_LAT + 2;  // read acceptance -> rd_out_vld

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr0_vld = 1'b0, wr1_vld = 1'b0, rd_vld = 1'b0, err_clr = 1'b0;
  logic [9:0]   wr0_adr = '0, wr1_adr = '0, rd_adr = '0;
  logic [7:0]   wr0_be = '0, wr1_be = '0;
  logic [511:0] wr0_dat = '0, wr1_dat = '0;
  logic         inj_sbe = 1'b0, inj_dbe = 1'b0, inj_pf = 1'b0;

  logic         wr0_rdy, wr1_rdy, rd_rdy;
  logic         rd_out_vld, rd_out_sbe, rd_out_dbe, rd_out_perr;
  logic [511:0] rd_out_dat, ram_wdat, ram_rdat;
  logic [9:0]   ram_wadr, ram_radr;
  logic [7:0]   ram_wen;
  logic [63:0]  ram_wpar, ram_rpar;
  logic         ram_ren, ram_rsbe, ram_rdbe;
  logic [15:0]  sbe_cnt, dbe_cnt, perr_cnt;

  always #5 clk = ~clk;

  dma_pcie_dsc_cpld_arb #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .wr0_vld(wr0_vld), .wr0_rdy(wr0_rdy), .wr0_adr(wr0_adr), .wr0_be(wr0_be), .wr0_dat(wr0_dat),
    .wr1_vld(wr1_vld), .wr1_rdy(wr1_rdy), .wr1_adr(wr1_adr), .wr1_be(wr1_be), .wr1_dat(wr1_dat),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_adr(rd_adr),
    .rd_out_vld(rd_out_vld), .rd_out_dat(rd_out_dat), .rd_out_sbe(rd_out_sbe),
    .rd_out_dbe(rd_out_dbe), .rd_out_perr(rd_out_perr),
    .ram_wadr(ram_wadr), .ram_wen(ram_wen), .ram_wpar(ram_wpar), .ram_wdat(ram_wdat),
    .ram_ren(ram_ren), .ram_radr(ram_radr),
    .ram_rpar(ram_rpar), .ram_rdat(ram_rdat), .ram_rsbe(ram_rsbe), .ram_rdbe(ram_rdbe),
    .err_clr(err_clr), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .perr_cnt(perr_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] bytepar(input logic [511:0] d);
    logic [63:0] p;
    for (int i = 0; i < 64; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  function automatic logic [511:0] pat(input logic [9:0] a);
    logic [7:0] b;
    b = a[7:0] ^ 8'hA5;
    return {64{b}};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- RAM model: stores data and parity, fixed read latency ----
  logic [511:0] mem  [1024];
  logic [63:0]  mpar [1024];
  logic [2:0]   inj_q;
  logic [511:0] st_dat [RD_LAT];
  logic [63:0]  st_par [RD_LAT];
  logic         st_sbe [RD_LAT];
  logic         st_dbe [RD_LAT];

  always @(posedge clk) begin
    inj_q <= {inj_sbe, inj_dbe, inj_pf};
    for (int l = 0; l < 8; l++) begin
      if (ram_wen[l] === 1'b1) begin
        mem[ram_wadr][64*l +: 64] <= ram_wdat[64*l +: 64];
        mpar[ram_wadr][8*l +: 8]  <= ram_wpar[8*l +: 8];
      end
    end
    st_dat[0] <= mem[ram_radr];
    st_par[0] <= mpar[ram_radr] ^ {63'd0, ram_ren & inj_q[0]};
    st_sbe[0] <= ram_ren & inj_q[2];
    st_dbe[0] <= ram_ren & inj_q[1];
    for (int s = 1; s < RD_LAT; s++) begin
      st_dat[s] <= st_dat[s-1];
      st_par[s] <= st_par[s-1];
      st_sbe[s] <= st_sbe[s-1];
      st_dbe[s] <= st_dbe[s-1];
    end
  end

  assign ram_rdat = st_dat[RD_LAT-1];
  assign ram_rpar = st_par[RD_LAT-1];
  assign ram_rsbe = st_sbe[RD_LAT-1];
  assign ram_rdbe = st_dbe[RD_LAT-1];

  // ---------------- reference model: expectations scheduled by cycle -------
  typedef struct {
    logic         wv;
    logic [7:0]   wen;
    logic [9:0]   wadr;
    logic [511:0] wdat;
    logic         ren;
    logic [9:0]   radr;
    logic         ov;
    logic [511:0] od;
    logic         osbe, odbe, operr;
  } slot_t;

  slot_t        sched [16];
  slot_t        blank;
  slot_t        cur;
  logic [511:0] sh [1024];
  logic         m_last;
  logic         primed = 1'b0;
  int           cyc = 0;
  int           m_sbe = 0, m_dbe = 0, m_perr = 0;

  always @(negedge clk) begin
    logic         e0, e1, er, racc, wany;
    logic [9:0]   wa;
    logic [7:0]   wb;
    logic [511:0] wd;
    int           k;
    k = cyc % 16;
    cur = sched[k];
    sched[k] = blank;
    if (primed) begin
      chk("ram_wen", ram_wen, cur.wen);
      if (cur.wv) begin
        chk("ram_wadr", ram_wadr, cur.wadr);
        chk("ram_wdat", ram_wdat, cur.wdat);
      end
      chk("ram_wpar", ram_wpar, bytepar(ram_wdat));
      chk("ram_ren", ram_ren, cur.ren);
      if (cur.ren) chk("ram_radr", ram_radr, cur.radr);
      chk("rd_out_vld", rd_out_vld, cur.ov);
      if (cur.ov) chk("rd_out_dat", rd_out_dat, cur.od);
      chk("rd_out_sbe", rd_out_sbe, cur.ov & cur.osbe);
      chk("rd_out_dbe", rd_out_dbe, cur.ov & cur.odbe);
      chk("rd_out_perr", rd_out_perr, cur.ov & cur.operr);
      chk("sbe_cnt", sbe_cnt, 16'(m_sbe));
      chk("dbe_cnt", dbe_cnt, 16'(m_dbe));
      chk("perr_cnt", perr_cnt, 16'(m_perr));
    end
    // who must be granted: the lone requester, or the one not served last
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst) begin
      if (wr0_vld && wr1_vld) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = wr0_vld;
        e1 = wr1_vld;
      end
    end
    wany = e0 | e1;
    wa   = e1 ? wr1_adr : wr0_adr;
    wb   = e1 ? wr1_be  : wr0_be;
    wd   = e1 ? wr1_dat : wr0_dat;
    er   = !rst && !(rd_vld && wany && (rd_adr == wa));
    racc = rd_vld && er;
    chk("wr0_rdy", wr0_rdy, e0);
    chk("wr1_rdy", wr1_rdy, e1);
    chk("rd_rdy", rd_rdy, er);
    if (rst) begin
      for (int i = 0; i < 16; i++) sched[i] = blank;
      m_last = 1'b1;
      m_sbe = 0; m_dbe = 0; m_perr = 0;
    end else begin
      if (err_clr) begin
        m_sbe = 0; m_dbe = 0; m_perr = 0;
      end else if (cur.ov) begin
        if (cur.osbe  && m_sbe  < 65535) m_sbe++;
        if (cur.odbe  && m_dbe  < 65535) m_dbe++;
        if (cur.operr && m_perr < 65535) m_perr++;
      end
      if (wany) begin
        sched[(cyc+1)%16].wv   = 1'b1;
        sched[(cyc+1)%16].wen  = wb;
        sched[(cyc+1)%16].wadr = wa;
        sched[(cyc+1)%16].wdat = wd;
        m_last = e1;
      end
      if (racc) begin
        sched[(cyc+1)%16].ren    = 1'b1;
        sched[(cyc+1)%16].radr   = rd_adr;
        sched[(cyc+RET)%16].ov    = 1'b1;
        sched[(cyc+RET)%16].od    = sh[rd_adr];
        sched[(cyc+RET)%16].osbe  = inj_sbe;
        sched[(cyc+RET)%16].odbe  = inj_dbe;
        sched[(cyc+RET)%16].operr = inj_pf;
      end
      // the write lands after any read accepted in the same cycle
      if (wany) begin
        for (int l = 0; l < 8; l++) if (wb[l]) sh[wa][64*l +: 64] = wd[64*l +: 64];
      end
    end
    primed = primed | rst;
    cyc++;
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_vld = 1'b0; wr1_vld = 1'b0; rd_vld = 1'b0; err_clr = 1'b0;
    inj_sbe = 1'b0; inj_dbe = 1'b0; inj_pf = 1'b0;
  endtask

  logic [9:0]   ra   [8];
  logic [511:0] rexp [8];
  logic [511:0] dpat;

  initial begin
    blank = '{default: '0};
    for (int i = 0; i < 16; i++) sched[i] = blank;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0; mpar[i] = '0; sh[i] = '0;
    end
    m_last = 1'b1;
    dpat = {8{64'hDEAD_BEEF_0123_4567}};

    // reset values
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_wr0_rdy", wr0_rdy, 1'b0);
    chk("rst_rd_rdy", rd_rdy, 1'b0);
    chk("rst_ram_wen", ram_wen, 8'h00);
    chk("rst_ram_ren", ram_ren, 1'b0);
    chk("rst_rd_out_vld", rd_out_vld, 1'b0);
    chk("rst_ram_wadr", ram_wadr, 10'h000);
    chk("rst_rd_out_dat", rd_out_dat, 512'd0);
    chk("rst_perr_cnt", perr_cnt, 16'h0000);
    step();
    rst = 1'b0;

    // contention: grants alternate starting with wr0, ram_wen one cycle later
    for (int k = 0; k < 4; k++) begin
      wr0_vld = 1'b1; wr1_vld = 1'b1;
      wr0_adr = 10'h100 + 10'(k); wr1_adr = 10'h100 + 10'(k);
      wr0_be = 8'hFF; wr1_be = 8'hFF;
      wr0_dat = pat(wr0_adr); wr1_dat = pat(wr1_adr);
      @(negedge clk);
      chk("rr_wr0", wr0_rdy, (k % 2) == 0);
      chk("rr_wr1", wr1_rdy, (k % 2) == 1);
      if (k > 0) begin
        chk("rr_wen", ram_wen, 8'hFF);
        chk("rr_wadr", ram_wadr, 10'h100 + 10'(k - 1));
      end
      step();
    end
    idle();
    @(negedge clk);
    chk("rr_wen_last", ram_wen, 8'hFF);
    chk("rr_wadr_last", ram_wadr, 10'h103);
    step();
    @(negedge clk);
    chk("rr_wen_idle", ram_wen, 8'h00);
    step();

    // parity of an all-0x01 write is all ones
    wr0_vld = 1'b1; wr0_adr = 10'h3FF; wr0_be = 8'hFF; wr0_dat = {64{8'h01}};
    @(negedge clk);
    chk("par_gnt", wr0_rdy, 1'b1);
    step();
    idle();
    @(negedge clk);
    chk("par_wpar", ram_wpar, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("par_wadr", ram_wadr, 10'h3FF);
    step();

    // read-after-write hazard on 0x010
    wr1_vld = 1'b1; wr1_adr = 10'h010; wr1_be = 8'hFF; wr1_dat = dpat;
    rd_vld = 1'b1; rd_adr = 10'h010;
    @(negedge clk);
    chk("raw_wr1_rdy", wr1_rdy, 1'b1);
    chk("raw_block", rd_rdy, 1'b0);
    step();
    wr1_vld = 1'b0;
    @(negedge clk);
    chk("raw_retry", rd_rdy, 1'b1);
    step();
    idle();
    step();
    step();
    @(negedge clk);
    chk("raw_not_yet", rd_out_vld, 1'b0);
    step();
    @(negedge clk);
    chk("raw_vld", rd_out_vld, 1'b1);
    chk("raw_dat", rd_out_dat, dpat);
    step();

    // eight back-to-back reads return in order on consecutive cycles
    ra[0] = 10'h100; ra[1] = 10'h101; ra[2] = 10'h102; ra[3] = 10'h103;
    ra[4] = 10'h3FF; ra[5] = 10'h010; ra[6] = 10'h020; ra[7] = 10'h030;
    for (int i = 0; i < 4; i++) rexp[i] = pat(ra[i]);
    rexp[4] = {64{8'h01}}; rexp[5] = dpat; rexp[6] = '0; rexp[7] = '0;
    for (int i = 0; i < 13; i++) begin
      if (i < 8) begin
        rd_vld = 1'b1; rd_adr = ra[i];
      end else begin
        rd_vld = 1'b0;
      end
      @(negedge clk);
      if (i < 8) chk("b2b_rdy", rd_rdy, 1'b1);
      if (i == 3 || i == 12) chk("b2b_gap", rd_out_vld, 1'b0);
      if (i >= 4 && i < 12) begin
        chk("b2b_vld", rd_out_vld, 1'b1);
        chk("b2b_dat", rd_out_dat, rexp[i-4]);
      end
      step();
    end
    idle();

    // forced dbe + parity flip, then err_clr racing the next error
    rd_vld = 1'b1; rd_adr = 10'h100; inj_dbe = 1'b1; inj_pf = 1'b1;
    @(negedge clk);
    chk("err_rdy", rd_rdy, 1'b1);
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("err_vld", rd_out_vld, 1'b1);
    chk("err_dbe", rd_out_dbe, 1'b1);
    chk("err_perr", rd_out_perr, 1'b1);
    chk("err_sbe", rd_out_sbe, 1'b0);
    step();
    rd_vld = 1'b1; rd_adr = 10'h101; inj_sbe = 1'b1;
    @(negedge clk);
    chk("err_dbe_cnt", dbe_cnt, 16'd1);
    chk("err_perr_cnt", perr_cnt, 16'd1);
    chk("err_sbe_cnt", sbe_cnt, 16'd0);
    step();
    idle();
    repeat (3) step();
    err_clr = 1'b1;
    @(negedge clk);
    chk("clr_sbe_flag", rd_out_sbe, 1'b1);
    step();
    idle();
    @(negedge clk);
    chk("clr_sbe_cnt", sbe_cnt, 16'd0);
    chk("clr_dbe_cnt", dbe_cnt, 16'd0);
    chk("clr_perr_cnt", perr_cnt, 16'd0);
    step();

    // random traffic with occasional hazards, errors, clears and resets
    for (int c = 0; c < 3000; c++) begin
      wr0_vld = ($urandom % 3) != 0;
      wr1_vld = ($urandom % 3) != 0;
      wr0_adr = 10'($urandom % 16);
      wr1_adr = 10'($urandom % 16);
      wr0_be  = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
      wr1_be  = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
      wr0_dat = rnd512();
      wr1_dat = rnd512();
      rd_vld  = ($urandom % 2) != 0;
      rd_adr  = (($urandom % 3) == 0) ? wr1_adr : 10'($urandom % 16);
      inj_sbe = ($urandom % 10) == 0;
      inj_dbe = ($urandom % 10) == 0;
      inj_pf  = ($urandom % 10) == 0;
      err_clr = ($urandom % 40) == 0;
      rst     = ($urandom % 300) == 0;
      step();
    end
    rst = 1'b0;
    idle();
    repeat (8) step();

    // reset one cycle after two reads are accepted drops both returns
    rd_vld = 1'b1; rd_adr = 10'h100;
    step();
    rd_adr = 10'h101;
    step();
    rd_vld = 1'b0; rst = 1'b1;
    wr0_vld = 1'b1; wr0_adr = 10'h055; wr0_be = 8'hFF; wr0_dat = pat(10'h055);
    @(negedge clk);
    chk("rst_wr_blocked", wr0_rdy, 1'b0);
    chk("rst_rd_blocked", rd_rdy, 1'b0);
    step();
    wr0_vld = 1'b0;
    @(negedge clk);
    chk("rst2_ram_ren", ram_ren, 1'b0);
    chk("rst2_ram_radr", ram_radr, 10'h000);
    chk("rst2_ram_wen", ram_wen, 8'h00);
    chk("rst2_ram_wdat", ram_wdat, 512'd0);
    chk("rst2_rd_out_dat", rd_out_dat, 512'd0);
    chk("rst2_sbe_cnt", sbe_cnt, 16'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst2_no_vld", rd_out_vld, 1'b0);
      chk("rst2_no_wen", ram_wen, 8'h00);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
